// File: rtl/sort_8_serializer.sv
// Sort-8 serializer: buffers sorted 8-word vectors leaving the bitonic merger and streams them out a word per beat.
// Latency: accept at edge E, FIFO write at E+PIPE_LAT, first word valid after edge E+PIPE_LAT+1.
// Backpressure: out_ready stalls the word stream; in_ready withholds credit once buffered+inflight vectors reach DEPTH.

// Vector FIFO with show-ahead head and next-entry peek.
// Latency: written entry is visible at head the cycle after the write edge.
// Backpressure: none internally; the caller guarantees no write while full and no pop while empty.
module sort_8_vec_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_vld,
    input  logic [W-1:0]           wr_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [W-1:0]           next_dat,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;

    assign rd_nxt   = rd_ptr + 1'b1;
    assign head_dat = mem[rd_ptr];
    assign next_dat = mem[rd_nxt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_nxt;
            case ({wr_vld, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Serializer top: credit-gates the stall-free merger, captures its outputs and emits words in index order.
// Latency: PIPE_LAT+1 clocks from accept to first word; back-to-back vectors stream with no bubble.
// Backpressure: out_ready holds out_* stable; in_ready drops while FIFO count plus inflight vectors reaches DEPTH.
module sort_8_serializer #(
    parameter int width    = 8,
    parameter int PIPE_LAT = 3,
    parameter int DEPTH    = 4,
    parameter bit DESC     = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:7][width-1:0]  indata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [width-1:0]       out_data,
    output logic [2:0]             out_idx,
    output logic                   out_last
);
    typedef logic [0:7][width-1:0] vec_t;
    typedef enum logic {IDLE, SEND} state_t;

    localparam int       VW    = 8 * width;
    localparam int       CW    = $clog2(DEPTH) + 1;
    localparam logic [2:0] FIRST = DESC ? 3'd7 : 3'd0;

    state_t            state;
    state_t            state_nxt;
    logic [PIPE_LAT-1:0] dly;
    logic              accept;
    logic              fifo_wr;
    logic              fifo_pop;
    logic [CW-1:0]     fifo_cnt;
    logic [VW-1:0]     head_raw;
    logic [VW-1:0]     next_raw;
    vec_t              head_vec;
    vec_t              next_vec;
    vec_t              load_vec;
    logic [31:0]       inflight;
    logic [2:0]        beat;
    logic [2:0]        beat_nxt;
    logic [2:0]        idx_step;
    logic [2:0]        idx_nxt;
    logic [width-1:0]  data_nxt;
    logic              valid_nxt;

    assign accept   = in_valid & in_ready;
    assign fifo_wr  = dly[PIPE_LAT-1];
    assign head_vec = head_raw;
    assign next_vec = next_raw;
    assign out_last = out_valid & (beat == 3'd7);

    // One bit per merger stage: which stages currently carry a credited vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly <= '0;
        end else begin
            dly[0] <= accept;
            for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) inflight = inflight + 32'(dly[i]);
    end

    // Pops free their slot only once fifo_cnt updates, i.e. on the following cycle.
    assign in_ready = (32'(fifo_cnt) + inflight) < 32'(DEPTH);

    sort_8_vec_fifo #(
        .W     (VW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_vld   (fifo_wr),
        .wr_dat   (indata),
        .pop      (fifo_pop),
        .head_dat (head_raw),
        .next_dat (next_raw),
        .cnt      (fifo_cnt)
    );

    assign idx_step = DESC ? (out_idx - 3'd1) : (out_idx + 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        valid_nxt = out_valid;
        data_nxt  = out_data;
        idx_nxt   = out_idx;
        fifo_pop  = 1'b0;
        load_vec  = head_vec;
        case (state)
            IDLE: begin
                if (fifo_cnt != '0) begin
                    state_nxt = SEND;
                    valid_nxt = 1'b1;
                    beat_nxt  = 3'd0;
                    idx_nxt   = FIRST;
                    data_nxt  = head_vec[FIRST];
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (beat != 3'd7) begin
                        beat_nxt = beat + 3'd1;
                        idx_nxt  = idx_step;
                        data_nxt = head_vec[idx_step];
                    end else begin
                        fifo_pop = 1'b1;
                        beat_nxt = 3'd0;
                        // A vector landing on this very edge is still in indata, not yet in the FIFO.
                        if (fifo_cnt > CW'(1) || fifo_wr) begin
                            load_vec = (fifo_cnt > CW'(1)) ? next_vec : indata;
                            idx_nxt  = FIRST;
                            data_nxt = load_vec[FIRST];
                        end else begin
                            valid_nxt = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            beat      <= '0;
        end else begin
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_idx   <= idx_nxt;
            beat      <= beat_nxt;
        end
    end
endmodule

// File: tb/tb_sort_8_serializer.sv
// Bench for sort_8_serializer: ascending and descending instances share stimulus, a behavioural merger
// model feeds indata, and per-instance scoreboards check every emitted word.
module tb_sort_8_serializer;
    localparam int W  = 8;
    localparam int PL = 3;
    localparam int D  = 4;

    typedef logic [0:7][W-1:0] vec_t;
    typedef struct packed {
        logic [W-1:0] dat;
        logic [2:0]   idx;
        logic         last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    vec_t       vec_raw = '0;
    vec_t       indata;
    vec_t       pv [PL];

    logic       in_ready_a, out_valid_a, out_last_a;
    logic [W-1:0] out_data_a;
    logic [2:0] out_idx_a;
    logic       in_ready_d, out_valid_d, out_last_d;
    logic [W-1:0] out_data_d;
    logic [2:0] out_idx_d;

    exp_t       sb_a[$];
    exp_t       sb_d[$];
    int         checks = 0;
    int         errors = 0;
    logic       acc;

    always #5 clk = ~clk;

    sort_8_serializer #(.width(W), .PIPE_LAT(PL), .DEPTH(D), .DESC(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .indata(indata),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_idx(out_idx_a), .out_last(out_last_a));

    sort_8_serializer #(.width(W), .PIPE_LAT(PL), .DEPTH(D), .DESC(1'b1)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d), .indata(indata),
        .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d),
        .out_idx(out_idx_d), .out_last(out_last_d));

    function automatic vec_t sort8(input vec_t v);
        vec_t r;
        logic [W-1:0] t;
        r = v;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (r[j] > r[j+1]) begin
                    t = r[j]; r[j] = r[j+1]; r[j+1] = t;
                end
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < 8; i++) r[i] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    // Behavioural merger: sorts whatever is presented and delivers it PL clocks later.
    always @(posedge clk) begin
        pv[0] <= sort8(vec_raw);
        for (int i = 1; i < PL; i++) pv[i] <= pv[i-1];
    end
    assign indata = pv[PL-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input vec_t s);
        for (int b = 0; b < 8; b++) begin
            sb_a.push_back('{dat: s[b], idx: 3'(b), last: (b == 7)});
            sb_d.push_back('{dat: s[7-b], idx: 3'(7 - b), last: (b == 7)});
        end
    endtask

    // One clock: drive at the falling edge, then score the handshakes the next rising edge will take.
    task automatic step(input logic iv, input vec_t v, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        vec_raw   = v;
        out_ready = ordy;
        acc = iv && in_ready_a;
        if (acc) push_exp(sort8(v));
        if (dut.fifo_wr) check("wr_not_full", 32'(dut.fifo_cnt < D), 1);
        if (out_valid_a && ordy) begin
            check("a_word_expected", 32'(sb_a.size() != 0), 1);
            if (sb_a.size() != 0) begin
                e = sb_a.pop_front();
                check("a_data", 32'(out_data_a), 32'(e.dat));
                check("a_idx",  32'(out_idx_a),  32'(e.idx));
                check("a_last", 32'(out_last_a), 32'(e.last));
            end
        end
        if (out_valid_d && ordy) begin
            check("d_word_expected", 32'(sb_d.size() != 0), 1);
            if (sb_d.size() != 0) begin
                e = sb_d.pop_front();
                check("d_data", 32'(out_data_d), 32'(e.dat));
                check("d_idx",  32'(out_idx_d),  32'(e.idx));
                check("d_last", 32'(out_last_d), 32'(e.last));
            end
        end
    endtask

    task automatic wait_out(input logic ordy, output int n);
        n = 0;
        do begin
            step(1'b0, '0, ordy);
            n++;
        end while (!out_valid_a && n < 60);
        check("wait_out_valid", 32'(out_valid_a), 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (sb_a.size() != 0 || sb_d.size() != 0); k++)
            step(1'b0, '0, 1'b1);
        check("drained", 32'(sb_a.size() + sb_d.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   n_acc;
        int   sent;
        vec_t v;

        // Reset state
        #1;
        check("rst_in_ready",  32'(in_ready_a),  1);
        check("rst_out_valid", 32'(out_valid_a), 0);
        check("rst_out_last",  32'(out_last_a),  0);
        check("rst_out_data",  32'(out_data_a),  0);
        check("rst_out_idx",   32'(out_idx_a),   0);
        check("rst_d_valid",   32'(out_valid_d), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single reverse-ordered vector, latency to first word
        for (int i = 0; i < 8; i++) v[i] = 8'(7 - i);
        step(1'b1, v, 1'b1);
        check("t1_accept", 32'(acc), 1);
        wait_out(1'b1, n);
        check("t1_latency", 32'(n), 32'(PL + 2));
        drain();

        // Stalled output: credits cap accepts at DEPTH, then a gap-free 32-word burst
        n_acc = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, rand_vec(), 1'b0);
            if (acc) n_acc++;
        end
        check("t3_accepts", 32'(n_acc), 32'(D));
        check("t3_in_ready_low", 32'(in_ready_a), 0);
        for (int k = 0; k < 32; k++) begin
            step(1'b0, '0, 1'b1);
            check("t3_no_bubble", 32'(out_valid_a), 1);
        end
        drain();

        // Back-to-back vectors with output always ready
        for (int k = 0; k < 3; k++) begin
            step(1'b1, rand_vec(), 1'b1);
            check("t4_accept", 32'(acc), 1);
        end
        wait_out(1'b1, n);
        for (int k = 0; k < 23; k++) begin
            step(1'b0, '0, 1'b1);
            check("t4_no_gap", 32'(out_valid_a), 1);
        end
        drain();

        // Random traffic with random backpressure
        sent = 0;
        for (int k = 0; k < 20000 && sent < 100; k++) begin
            step($urandom_range(0, 3) != 0, rand_vec(), 1'($urandom_range(0, 1)));
            if (acc) sent++;
        end
        check("t5_sent", 32'(sent), 100);
        drain();

        // Reset during beat 3 discards everything
        step(1'b1, rand_vec(), 1'b1);
        n = 0;
        do begin
            step(1'b0, '0, 1'b1);
            n++;
        end while (!(out_valid_a && out_idx_a == 3'd3) && n < 40);
        check("t6_reach_beat3", 32'(out_valid_a && out_idx_a == 3'd3), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid_drop",   32'(out_valid_a), 0);
        check("t6_d_valid_drop", 32'(out_valid_d), 0);
        check("t6_in_ready",     32'(in_ready_a),  1);
        check("t6_d_in_ready",   32'(in_ready_d),  1);
        check("t6_last",         32'(out_last_a),  0);
        sb_a.delete();
        sb_d.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, '0, 1'b1);
            check("t6_quiet", 32'(out_valid_a | out_valid_d), 0);
        end
        step(1'b1, rand_vec(), 1'b1);
        check("t6_new_accept", 32'(acc), 1);
        wait_out(1'b1, n);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
